// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: arbiter states, port indices and the port-selection rule
package vram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  localparam logic [1:0] PORT_VIDEO = 2'd0;
  localparam logic [1:0] PORT_CPU   = 2'd1;
  localparam logic [1:0] PORT_DMA   = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;
  // Video wins unless starved peers must get a slot; peers alternate away from rr_last.
  function automatic logic [1:0] pick(input logic [2:0] req, input logic starve_hit, input logic [1:0] rr_last);
    return (req[0] && !starve_hit) ? PORT_VIDEO :
           (req[1] && req[2]) ? ((rr_last == PORT_CPU) ? PORT_DMA : PORT_CPU) :
           req[1] ? PORT_CPU : req[2] ? PORT_DMA : GRANT_NONE;
  endfunction
endpackage

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM port between video fetch, CPU and DMA requesters
module vram_arbiter import vram_arbiter_pkg::*; #(
  parameter int MAX_BURST = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_p0_request,
  input  logic        i_p0_rw,
  input  logic [31:0] i_p0_address,
  input  logic [31:0] i_p0_wdata,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ready,
  input  logic        i_p1_request,
  input  logic        i_p1_rw,
  input  logic [31:0] i_p1_address,
  input  logic [31:0] i_p1_wdata,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ready,
  input  logic        i_p2_request,
  input  logic        i_p2_rw,
  input  logic [31:0] i_p2_address,
  input  logic [31:0] i_p2_wdata,
  output logic [31:0] o_p2_rdata,
  output logic        o_p2_ready,
  output logic        o_mem_request,
  output logic        o_mem_rw,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [1:0]  o_grant,
  output logic        o_busy
);
  localparam logic [7:0] MAX_Q = 8'(MAX_BURST);
  state_t state_q, state_d;
  logic [1:0] grant_q, grant_d, rr_last_q, rr_last_d, sel;
  logic [7:0] starve_q, starve_d;
  logic mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0] ready_q, ready_d, req;
  logic [31:0] rdata_q [3];
  logic [31:0] rdata_d [3];
  logic low_pend, starve_hit, cur_req, sel_rw;
  logic [31:0] sel_addr, sel_wdata;
  assign req = {i_p2_request, i_p1_request, i_p0_request};
  assign low_pend = req[1] | req[2];
  assign starve_hit = (starve_q == MAX_Q) && low_pend;
  assign sel = pick(req, starve_hit, rr_last_q);
  assign sel_rw = sel == PORT_VIDEO ? i_p0_rw : sel == PORT_CPU ? i_p1_rw : i_p2_rw;
  assign sel_addr = sel == PORT_VIDEO ? i_p0_address : sel == PORT_CPU ? i_p1_address : i_p2_address;
  assign sel_wdata = sel == PORT_VIDEO ? i_p0_wdata : sel == PORT_CPU ? i_p1_wdata : i_p2_wdata;
  assign cur_req = grant_q == PORT_VIDEO ? req[0] : grant_q == PORT_CPU ? req[1] : req[2];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_last_d = rr_last_q;
    starve_d = starve_q;
    mem_req_d = mem_req_q;
    mem_rw_d = mem_rw_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (sel != GRANT_NONE) begin
        state_d = BUSY;
        grant_d = sel;
        mem_req_d = 1'b1;
        mem_rw_d = sel_rw;
        mem_addr_d = sel_addr;
        mem_wdata_d = sel_wdata;
        rr_last_d = (sel == PORT_VIDEO) ? rr_last_q : sel;
        starve_d = (sel != PORT_VIDEO || !low_pend) ? '0 : (starve_q == MAX_Q) ? starve_q : starve_q + 8'd1;
      end
      BUSY: if (i_mem_ready) begin
        state_d = GAP;
        mem_req_d = 1'b0;
        // A requester that abandoned its request gets no completion pulse.
        for (int i = 0; i < 3; i++)
          if (cur_req && grant_q == 2'(i)) begin
            ready_d[i] = 1'b1;
            rdata_d[i] = i_mem_rdata;
          end
      end
      GAP: begin
        state_d = IDLE;
        ready_d = '0;
        grant_d = GRANT_NONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
      rr_last_q <= PORT_DMA;
      starve_q <= '0;
      mem_req_q <= 1'b0;
      mem_rw_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      ready_q <= '0;
      rdata_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_last_q <= rr_last_d;
      starve_q <= starve_d;
      mem_req_q <= mem_req_d;
      mem_rw_q <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end
  assert property (@(posedge i_clock) disable iff (i_reset) (state_q != BUSY || cur_req))
    else $error("vram_arbiter: request dropped while its transaction was in flight");
  assign o_mem_request = mem_req_q;
  assign o_mem_rw = mem_rw_q;
  assign o_mem_address = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_grant = grant_q;
  assign o_busy = state_q != IDLE;
  assign {o_p2_ready, o_p1_ready, o_p0_ready} = ready_q;
  assign o_p0_rdata = rdata_q[0];
  assign o_p1_rdata = rdata_q[1];
  assign o_p2_rdata = rdata_q[2];
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scenarios checked every cycle against a transaction-level arbiter model
module tb_vram_arbiter;
  localparam int MAXB = 4;
  typedef struct packed {logic rw; logic [31:0] addr; logic [31:0] wd;} txn_t;
  logic clk, rst;
  logic breq [3];
  logic brw [3];
  logic [31:0] badr [3];
  logic [31:0] bwd [3];
  logic [2:0] d_rdy;
  logic [31:0] d_rd [3];
  logic o_mem_request, o_mem_rw, o_busy, mrdy;
  logic [31:0] o_mem_address, o_mem_wdata, mrdata;
  logic [1:0] o_grant;
  txn_t q0[$], q1[$], q2[$];
  int n_chk = 0, n_fail = 0, cyc = 0, mlat = 1, mcnt = 0;
  bit chk_en = 0, prev_mreq = 0;
  int dut_glog[$], m_glog[$], rise_q[$];
  logic [31:0] addr_log[$];
  int rdy_cnt [3];
  bit m_act, m_gap;
  int m_grant, m_starve, m_last;
  logic m_mreq, m_rw;
  logic [31:0] m_adr, m_wd;
  logic [2:0] m_rdy;
  logic [31:0] m_rd [3];

  vram_arbiter #(.MAX_BURST(MAXB)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_p0_request(breq[0]), .i_p0_rw(brw[0]), .i_p0_address(badr[0]), .i_p0_wdata(bwd[0]),
    .o_p0_rdata(d_rd[0]), .o_p0_ready(d_rdy[0]),
    .i_p1_request(breq[1]), .i_p1_rw(brw[1]), .i_p1_address(badr[1]), .i_p1_wdata(bwd[1]),
    .o_p1_rdata(d_rd[1]), .o_p1_ready(d_rdy[1]),
    .i_p2_request(breq[2]), .i_p2_rw(brw[2]), .i_p2_address(badr[2]), .i_p2_wdata(bwd[2]),
    .o_p2_rdata(d_rd[2]), .o_p2_ready(d_rdy[2]),
    .o_mem_request(o_mem_request), .o_mem_rw(o_mem_rw), .o_mem_address(o_mem_address),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mrdata), .i_mem_ready(mrdy),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_log(input string nm, input int got[$], input int exp[$]);
    chk({nm, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  // Requesters: hold the head transaction until its ready pulse, then present the next one.
  always @(negedge clk) begin
    if (d_rdy[0] && q0.size() != 0) void'(q0.pop_front());
    if (d_rdy[1] && q1.size() != 0) void'(q1.pop_front());
    if (d_rdy[2] && q2.size() != 0) void'(q2.pop_front());
    breq[0] = q0.size() != 0;
    breq[1] = q1.size() != 0;
    breq[2] = q2.size() != 0;
    if (breq[0]) {brw[0], badr[0], bwd[0]} = q0[0];
    if (breq[1]) {brw[1], badr[1], bwd[1]} = q1[0];
    if (breq[2]) {brw[2], badr[2], bwd[2]} = q2[0];
  end

  // Memory: ready pulse mlat cycles after the request is seen.
  always @(negedge clk) begin
    if (rst || !o_mem_request || mrdy) begin
      mrdy = 0;
      mcnt = 0;
    end else begin
      mcnt++;
      if (mcnt >= mlat) begin
        mrdy = 1;
        mrdata = mem_fn(o_mem_address);
      end
    end
  end

  function automatic int winner();
    bit low = breq[1] || breq[2];
    if (breq[0] && !(low && m_starve == MAXB)) return 0;
    if (breq[1] && breq[2]) return (m_last == 1) ? 2 : 1;
    if (breq[1]) return 1;
    if (breq[2]) return 2;
    return 3;
  endfunction

  // Model: one transaction at a time, granted from idle, completed by memory, then a one-cycle gap.
  always @(posedge clk) begin
    int w;
    cyc++;
    if (rst) begin
      m_act = 0; m_gap = 0; m_grant = 3; m_mreq = 0; m_rw = 0; m_adr = 0; m_wd = 0;
      m_rdy = 0; m_rd = '{0, 0, 0}; m_starve = 0; m_last = 2;
    end else if (m_gap) begin
      m_act = 0; m_gap = 0; m_rdy = 0; m_grant = 3;
    end else if (m_act) begin
      if (mrdy) begin
        m_mreq = 0;
        m_gap = 1;
        if (breq[m_grant]) begin
          m_rdy[m_grant] = 1;
          m_rd[m_grant] = mrdata;
        end
      end
    end else begin
      w = winner();
      if (w != 3) begin
        m_act = 1; m_grant = w; m_mreq = 1; m_rw = brw[w]; m_adr = badr[w]; m_wd = bwd[w];
        m_glog.push_back(w);
        if (w == 0) m_starve = (breq[1] || breq[2]) ? ((m_starve < MAXB) ? m_starve + 1 : MAXB) : 0;
        else begin
          m_starve = 0;
          m_last = w;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) rdy_cnt[i] += int'(d_rdy[i]);
      if (o_mem_request && !prev_mreq) begin
        dut_glog.push_back(int'(o_grant));
        rise_q.push_back(cyc);
        addr_log.push_back(o_mem_address);
      end
      prev_mreq = o_mem_request;
      chk("grant", o_grant, m_grant);
      chk("busy", o_busy, m_act);
      chk("mem_request", o_mem_request, m_mreq);
      chk("mem_rw", o_mem_rw, m_rw);
      chk("mem_address", o_mem_address, m_adr);
      chk("mem_wdata", o_mem_wdata, m_wd);
      chk("ready", d_rdy, m_rdy);
      for (int i = 0; i < 3; i++) chk($sformatf("p%0d_rdata", i), d_rd[i], m_rd[i]);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_en = 1;
    chk("reset grant", o_grant, 3);
    chk("reset mem_request", o_mem_request, 0);
    chk("reset busy", o_busy, 0);
    chk("reset ready", d_rdy, 0);
    rst = 0;
    dut_glog.delete(); m_glog.delete(); rise_q.delete(); addr_log.delete();
    rdy_cnt = '{0, 0, 0};
  endtask

  task automatic wait_done(input int lim, input string nm);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 || o_busy) begin
      @(negedge clk);
      n++;
      if (n > lim) begin
        n_chk++; n_fail++;
        $display("FAIL %s: not idle after %0d cycles", nm, lim);
        return;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input logic [1:0] g, input int lim, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_grant != g && n < lim);
    chk({nm, " grant seen"}, o_grant, g);
  endtask

  initial begin
    int exp_q[$];
    int bad_a, bad_s, nb;
    rst = 1;
    breq = '{0, 0, 0}; brw = '{0, 0, 0}; badr = '{0, 0, 0}; bwd = '{0, 0, 0};
    mrdy = 0; mrdata = 0;
    do_reset();

    mlat = 2;
    @(posedge clk) q1.push_back(txn_t'{1'b0, 32'h100, 32'h0});
    wait_done(50, "cpu read");
    exp_q = '{1};
    chk_log("cpu read dut grants", dut_glog, exp_q);
    chk_log("cpu read model grants", m_glog, exp_q);
    chk("cpu read rdata", d_rd[1], 32'hDEADBEEF);
    chk("cpu read ready cycles", rdy_cnt[1], 1);

    do_reset();
    mlat = 1;
    @(posedge clk);
    q0.push_back(txn_t'{1'b0, 32'h10, 32'h0});
    q1.push_back(txn_t'{1'b0, 32'h20, 32'h0});
    q2.push_back(txn_t'{1'b0, 32'h30, 32'h0});
    wait_grant(1, 20, "simultaneous");
    @(posedge clk) q0.push_back(txn_t'{1'b0, 32'h14, 32'h0});
    wait_done(60, "simultaneous");
    exp_q = '{0, 1, 0, 2};
    chk_log("simultaneous dut grants", dut_glog, exp_q);
    chk_log("simultaneous model grants", m_glog, exp_q);

    do_reset();
    @(posedge clk);
    for (int i = 0; i < 10; i++) q0.push_back(txn_t'{1'b0, 32'h1000 + 32'(4 * i), 32'h0});
    q1.push_back(txn_t'{1'b0, 32'h200, 32'h0});
    wait_grant(1, 40, "starvation");
    @(posedge clk) q1.push_back(txn_t'{1'b0, 32'h204, 32'h0});
    wait_done(100, "starvation");
    exp_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    chk_log("starvation dut grants", dut_glog, exp_q);
    chk_log("starvation model grants", m_glog, exp_q);

    do_reset();
    @(posedge clk);
    for (int i = 0; i < 160; i++) q0.push_back(txn_t'{1'b0, 32'h8000 + 32'(4 * i), 32'h0});
    wait_done(700, "burst");
    chk("burst ready pulses", rdy_cnt[0], 160);
    chk("burst dut grants", dut_glog.size(), 160);
    chk("burst model grants", m_glog.size(), 160);
    bad_a = 0;
    bad_s = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != 32'h8000 + 32'(4 * i)) bad_a++;
    for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 3) bad_s++;
    chk("burst address order errors", bad_a, 0);
    chk("burst 3-cycle spacing errors", bad_s, 0);

    do_reset();
    mlat = 3;
    nb = 0;
    @(posedge clk) q2.push_back(txn_t'{1'b1, 32'h2000, 32'h12345678});
    for (int n = 0; n < 40 && (q2.size() != 0 || o_busy); n++) begin
      @(negedge clk);
      if (o_mem_request) begin
        nb++;
        chk("write mem_rw", o_mem_rw, 1);
        chk("write mem_address", o_mem_address, 32'h2000);
        chk("write mem_wdata", o_mem_wdata, 32'h12345678);
      end
    end
    wait_done(10, "write");
    chk("write request cycles", nb, 3);
    chk("write p2 ready cycles", rdy_cnt[2], 1);

    do_reset();
    mlat = 6;
    @(posedge clk) q1.push_back(txn_t'{1'b0, 32'h300, 32'h0});
    wait_grant(1, 20, "reset in busy");
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    chk("mid reset mem_request", o_mem_request, 0);
    chk("mid reset grant", o_grant, 3);
    chk("mid reset ready", d_rdy, 0);
    chk("mid reset busy", o_busy, 0);
    mlat = 1;
    wait_done(50, "post reset");
    chk("post reset p1 ready cycles", rdy_cnt[1], 1);
    chk("post reset p1 rdata", d_rd[1], mem_fn(32'h300));
    chk("post reset grant count", dut_glog.size(), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Three-requester arbiter that shares one 32-bit VRAM port between the video scanline fetcher, the CPU/video-controller path and a blitter/DMA engine. It sits between the video controller's memory ports and the VRAM/SDRAM controller, replacing the current dual-port arrangement with a single arbitrated port. Port 0 (video fetch) has priority, bounded by a starvation limit. Ports 1 and 2 share the remaining slots round-robin.

## Interface
Parameters:
- MAX_BURST, default 16: consecutive port-0 grants allowed while port 1 or 2 is pending before one forced low-priority grant; legal range 1..255.

Ports:
- i_clock  in  1  clock; every register updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_pN_request  in  1  port N (N=0,1,2) request; held until o_pN_ready.
- i_pN_rw  in  1  port N direction, 1 = write.
- i_pN_address  in  32  port N byte address, forwarded unmodified.
- i_pN_wdata  in  32  port N write data.
- o_pN_rdata  out  32  port N read data, valid while o_pN_ready=1.
- o_pN_ready  out  1  port N completion, single-cycle pulse.
- o_mem_request  out  1  memory request, held until i_mem_ready.
- o_mem_rw  out  1  memory direction.
- o_mem_address  out  32  memory address.
- o_mem_wdata  out  32  memory write data.
- i_mem_rdata  in  32  memory read data, valid with i_mem_ready.
- i_mem_ready  in  1  memory completion, single-cycle pulse.
- o_grant  out  2  index of the port being served; 2'd3 when idle.
- o_busy  out  1  1 while in BUSY or GAP.

## Operation
- Reset: state=IDLE, o_grant=3, every o_*/o_mem_* output=0, starve_cnt=0, rr_last=2 (so port 1 wins the first low-priority tie).
- IDLE: sample all three requests. Selection:
  - If port 0 requests and not (starve_cnt==MAX_BURST with port 1 or 2 pending), select port 0.
  - Otherwise select port 1 or 2 by round-robin: prefer the port other than rr_last.
  - On selection: latch rw/address/wdata onto o_mem_*, set o_mem_request=1, o_grant=N, go to BUSY.
- BUSY: wait for i_mem_ready.
  - On i_mem_ready: o_mem_request=0; o_pN_ready=1 and o_pN_rdata=i_mem_rdata for the granted port only; go to GAP.
- GAP: all readies drop to 0 and o_grant=3. Go to IDLE without sampling requests. This lets a requester that saw ready either deassert or present a new address, which supports back-to-back scanline bursts with the request held high.
- starve_cnt:
  - On a port-0 grant while port 1 or 2 is requesting: increment, saturating at MAX_BURST.
  - On any port-1/2 grant: clear to 0. rr_last is updated only on port-1/2 grants.
  - On a port-0 grant with no low-priority request pending: clear to 0.
- Requests and data of non-granted ports are ignored. Their o_pN_rdata holds its last value.
- Request dropped during BUSY is a protocol violation. The memory transaction completes, no ready pulse is issued, and the simulation asserts $error.
- Reset mid-transaction: the in-flight access is abandoned and o_mem_request drops in the same cycle. The memory controller must share i_reset.

## Timing
- Grant latency: a request seen at IDLE edge e0 produces o_mem_request=1 visible after e0.
- Completion: i_mem_ready sampled at edge e1 produces o_pN_ready/o_pN_rdata visible after e1 (one registered stage).
- Minimum transaction: IDLE→BUSY→GAP, i.e. 3 cycles per access when memory returns ready one cycle after the request.
- Back-to-back on one port: the next grant is issued at the edge following GAP (edge e1+2).
- Rearbitration happens only in IDLE; priority never preempts a BUSY transaction.
- o_mem_* fields are stable for the whole BUSY state.

## Structure
- Package vram_arbiter_pkg holds:
  - state typedef enum {IDLE, BUSY, GAP};
  - constants PORT_VIDEO=0, PORT_CPU=1, PORT_DMA=2, GRANT_NONE=3;
  - a pure function pick(req[2:0], starve_hit, rr_last) returning the 2-bit index.
- No sub-module is needed. The per-port request/response muxing is three-way and stays inline.

## Test plan
- Single CPU read: p1 read 0x100, memory returns 0xDEADBEEF after 2 cycles → o_p1_ready pulse of 1 cycle with rdata 0xDEADBEEF; o_grant goes 1 then 3.
- Simultaneous requests: p0, p1 and p2 all requested in the same cycle → grant order 0, 1, 0, 2 for MAX_BURST≥2 with p0 re-requesting each time.
- Starvation: MAX_BURST=4, p0 streams continuously, p1 held → p1 is granted after exactly 4 p0 grants; starve_cnt returns to 0.
- Video burst: p0 holds request high, advancing the address by 4 after each ready across 160 words → 160 ready pulses, each transaction 3 cycles with single-cycle memory, addresses in order.
- Write passthrough: p2 write 0x2000←0x12345678 → o_mem_rw=1 with matching address/wdata held stable through BUSY; o_p2_ready pulse.
- Reset in BUSY: assert i_reset while p1 is granted → next cycle o_mem_request=0, all ready=0, o_grant=3; a post-reset p1 request completes normally.
